// File: rtl/tlb_entry_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlb_entry_pkg                                                            |
// | Shared flag indices, entry struct and mask constants for TLB entries.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package tlb_entry_pkg;

    localparam int FLAGS_W       = 16;
    localparam int PPN_W_DEFAULT = 20;

    localparam int FLAG_C        = 0;
    localparam int FLAG_EFF      = 1;
    localparam int FLAG_PAA      = 2;
    localparam int FLAG_PAL      = 3;
    localparam int FLAG_PPP      = 4;
    localparam int FLAG_PR       = 5;
    localparam int FLAG_PX       = 6;
    localparam int FLAG_PW       = 7;
    localparam int FLAG_SR       = 8;
    localparam int FLAG_SX       = 9;
    localparam int FLAG_SW       = 10;
    localparam int FLAG_GF       = 11;
    localparam int FLAG_PF       = 12;
    localparam int FLAG_AE_FINAL = 13;
    localparam int FLAG_AE_PTW   = 14;
    localparam int FLAG_U        = 15;

    typedef struct packed {
        logic [PPN_W_DEFAULT-1:0] ppn;
        logic [FLAGS_W-1:0]       flags;
    } tlb_entry_t;

    localparam logic [FLAGS_W-1:0] PERM_MASK =
        (FLAGS_W'(1) << FLAG_SW) | (FLAGS_W'(1) << FLAG_SX) | (FLAGS_W'(1) << FLAG_SR) |
        (FLAGS_W'(1) << FLAG_PW) | (FLAGS_W'(1) << FLAG_PX) | (FLAGS_W'(1) << FLAG_PR);

    localparam logic [FLAGS_W-1:0] FAULT_MASK =
        (FLAGS_W'(1) << FLAG_PF) | (FLAGS_W'(1) << FLAG_GF) |
        (FLAGS_W'(1) << FLAG_AE_PTW) | (FLAGS_W'(1) << FLAG_AE_FINAL);

endpackage
`default_nettype wire

// File: rtl/tlb_entry_perm_mask.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlb_entry_perm_mask                                                      |
// | Clears permission bits of an entry whenever any fault bit is set.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tlb_entry_perm_mask
    import tlb_entry_pkg::*;
(
    input  logic [FLAGS_W-1:0] flags_i,
    output logic [FLAGS_W-1:0] flags_o
);

    logic w_fault;

    assign w_fault = |(flags_i & FAULT_MASK);
    assign flags_o = w_fault ? (flags_i & ~PERM_MASK) : flags_i;

endmodule
`default_nettype wire

// File: rtl/tlb_entry_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlb_entry_slice                                                          |
// | DEPTH-entry registered FIFO for PTW->TLB refill entries with flush.      |
// | Option: TLB_ENTRY_SLICE_PERM_MASK_EN masks perms of faulting head entry. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tlb_entry_slice
    import tlb_entry_pkg::*;
#(
    parameter  int PPN_W = PPN_W_DEFAULT,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PPN_W-1:0]   in_ppn,
    input  logic [FLAGS_W-1:0] in_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PPN_W-1:0]   out_ppn,
    output logic [FLAGS_W-1:0] out_flags,
    output logic [CNT_W-1:0]   count
);

    localparam int               PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_LAST  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PPN_W-1:0]   ppn_q   [DEPTH];
    logic [FLAGS_W-1:0] flags_q [DEPTH];
    logic               w_push, w_pop;
    logic [FLAGS_W-1:0] w_flags_raw;

    // Handshake depends only on held state and flush, never on out_ready.
    assign in_ready  = (count_q < c_DEPTH_CNT) & ~flush;
    assign out_valid = (count_q != '0) & ~flush;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ppn_q[i]   <= '0;
                flags_q[i] <= '0;
            end
        end else if (w_push) begin
            ppn_q[wr_ptr_q]   <= in_ppn;
            flags_q[wr_ptr_q] <= in_flags;
        end
    end

    assign out_ppn     = ppn_q[rd_ptr_q];
    assign w_flags_raw = flags_q[rd_ptr_q];

`ifdef TLB_ENTRY_SLICE_PERM_MASK_EN
    tlb_entry_perm_mask u_perm_mask (
        .flags_i (w_flags_raw),
        .flags_o (out_flags)
    );
`else
    assign out_flags = w_flags_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlb_entry_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tlb_entry_slice                                                       |
// | Self-checking bench: DEPTH=2 and DEPTH=3 instances against a queue model.|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_tlb_entry_slice;

    logic        clock;
    logic        reset_n;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [19:0] in_ppn    [2];
    logic [15:0] in_flags  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [19:0] out_ppn   [2];
    logic [15:0] out_flags [2];
    logic [1:0]  count     [2];

    int errors = 0;
    int checks = 0;

    // Reference model: one arrival-ordered queue of {ppn, flags} per instance.
    logic [35:0] mq [2][$];

    tlb_entry_slice #(.PPN_W(20), .DEPTH(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_ppn(in_ppn[0]), .in_flags(in_flags[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_ppn(out_ppn[0]), .out_flags(out_flags[0]), .count(count[0])
    );

    tlb_entry_slice #(.PPN_W(20), .DEPTH(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_ppn(in_ppn[1]), .in_flags(in_flags[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_ppn(out_ppn[1]), .out_flags(out_flags[1]), .count(count[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int depth_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic [15:0] exp_flags(input logic [15:0] f);
        logic [15:0] r;
        r = f;
`ifdef TLB_ENTRY_SLICE_PERM_MASK_EN
        if (f[12] || f[11] || f[14] || f[13]) begin
            r[10] = 1'b0; r[9] = 1'b0; r[8] = 1'b0;
            r[7]  = 1'b0; r[6] = 1'b0; r[5] = 1'b0;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input int d, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [dut%0d] t=%0t got=%h want=%h", nm, depth_of(d), $time, act, exp);
        end
    endtask

    // Called just after a negedge with inputs set: checks both instances, then advances the model.
    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            int   sz;
            logic e_ir, e_ov;
            sz   = mq[d].size();
            e_ir = (sz < depth_of(d)) && !flush[d];
            e_ov = (sz != 0) && !flush[d];
            chk("model_in_ready",  d, 36'(in_ready[d]),  36'(e_ir));
            chk("model_out_valid", d, 36'(out_valid[d]), 36'(e_ov));
            chk("model_count",     d, 36'(count[d]),     36'(sz));
            if (e_ov) begin
                chk("model_out_ppn",   d, 36'(out_ppn[d]),   36'(mq[d][0][35:16]));
                chk("model_out_flags", d, 36'(out_flags[d]), 36'(exp_flags(mq[d][0][15:0])));
            end
        end
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            int   sz;
            logic e_ir, e_ov;
            sz   = mq[d].size();
            e_ir = (sz < depth_of(d)) && !flush[d];
            e_ov = (sz != 0) && !flush[d];
            if (flush[d]) begin
                mq[d].delete();
            end else begin
                if (e_ov && out_ready[d]) void'(mq[d].pop_front());
                if (e_ir && in_valid[d])  mq[d].push_back({in_ppn[d], in_flags[d]});
            end
        end
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            in_ppn[d] = '0;  in_flags[d] = '0;
        end
    endtask

    typedef struct {
        logic        iv, ordy, fl;
        logic [19:0] ppn;
        logic        e_ir, e_ov;
        int          e_cnt;
        logic [19:0] e_ppn;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Fill/full ordering, then flush with a concurrent push and pop (DEPTH=2).
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 20'hA,  1'b1, 1'b0, 0, 20'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 20'hB,  1'b1, 1'b1, 1, 20'hA};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 20'hC,  1'b0, 1'b1, 2, 20'hA};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 20'hC,  1'b0, 1'b1, 2, 20'hA};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 20'h0,  1'b1, 1'b1, 1, 20'hB};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 20'h0,  1'b1, 1'b0, 0, 20'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 20'hD,  1'b1, 1'b0, 0, 20'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 20'hE,  1'b1, 1'b1, 1, 20'hD};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 20'hF,  1'b0, 1'b0, 2, 20'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 20'h0,  1'b1, 1'b0, 0, 20'h0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 20'h77, 1'b1, 1'b0, 0, 20'h0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 20'h0,  1'b1, 1'b1, 1, 20'h77};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 20'h0,  1'b1, 1'b0, 0, 20'h0};

        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, 36'(out_valid[d]), 36'(0));
            chk("rst_in_ready",  d, 36'(in_ready[d]),  36'(1));
            chk("rst_count",     d, 36'(count[d]),     36'(0));
            chk("rst_out_ppn",   d, 36'(out_ppn[d]),   36'(0));
            chk("rst_out_flags", d, 36'(out_flags[d]), 36'(0));
        end
        @(negedge clock);
        reset_n = 1'b1;

        // First entry becomes visible exactly one cycle after the push.
        in_valid[0] = 1'b1; in_ppn[0] = 20'h12345; in_flags[0] = 16'h0E40;
        tick();
        in_valid[0] = 1'b0;
        #1;
        chk("first_out_valid", 0, 36'(out_valid[0]), 36'(1));
        chk("first_out_ppn",   0, 36'(out_ppn[0]),   36'(20'h12345));
        chk("first_out_flags", 0, 36'(out_flags[0]), 36'(exp_flags(16'h0E40)));
        chk("first_count",     0, 36'(count[0]),     36'(1));
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        for (int i = 0; i < 13; i++) begin
            in_valid[0] = tbl[i].iv; out_ready[0] = tbl[i].ordy; flush[0] = tbl[i].fl;
            in_ppn[0] = tbl[i].ppn;  in_flags[0] = 16'h0021;
            #1;
            chk($sformatf("tbl%0d_in_ready", i),  0, 36'(in_ready[0]),  36'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 0, 36'(out_valid[0]), 36'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_count", i),     0, 36'(count[0]),     36'(tbl[i].e_cnt));
            if (tbl[i].e_ov)
                chk($sformatf("tbl%0d_out_ppn", i), 0, 36'(out_ppn[0]), 36'(tbl[i].e_ppn));
            tick();
        end
        idle_inputs();

        // Faulting entry (pf, sr, pr, u set): permission bits depend on the mask option.
        in_valid[0] = 1'b1; in_ppn[0] = 20'h00ABC; in_flags[0] = 16'h9120;
        tick();
        in_valid[0] = 1'b0;
        #1;
        chk("mask_out_flags", 0, 36'(out_flags[0]), 36'(exp_flags(16'h9120)));
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // DEPTH=3 at count=1: ten simultaneous push/pop cycles walk the pointers through wrap.
        in_valid[1] = 1'b1; in_ppn[1] = 20'h00100; in_flags[1] = 16'h0001;
        tick();
        for (int i = 0; i < 10; i++) begin
            in_valid[1] = 1'b1; out_ready[1] = 1'b1; in_ppn[1] = 20'h000C0 + 20'(i);
            tick();
            #1;
            chk("pp_count",   1, 36'(count[1]),   36'(1));
            chk("pp_out_ppn", 1, 36'(out_ppn[1]), 36'(20'h000C0 + 20'(i)));
        end
        in_valid[1] = 1'b0;
        tick();
        out_ready[1] = 1'b0;

        // Asynchronous reset between clock edges with two entries held.
        in_valid[0] = 1'b1; in_ppn[0] = 20'h00001;
        tick();
        in_ppn[0] = 20'h00002;
        tick();
        in_valid[0] = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count",     0, 36'(count[0]),     36'(0));
        chk("async_rst_out_valid", 0, 36'(out_valid[0]), 36'(0));
        mq[0].delete();
        mq[1].delete();
        @(negedge clock);
        reset_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = ($urandom_range(0, 9) < 7);
                out_ready[d] = ($urandom_range(0, 9) < 6);
                flush[d]     = ($urandom_range(0, 19) == 0);
                in_ppn[d]    = 20'($urandom);
                in_flags[d]  = 16'($urandom);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlb_entry_slice.md
Name: tlb_entry_slice

Overview:
- Parametrised elastic buffer for TLB/PTW entry bundles (PPN plus 16 permission/attribute flags) between the PTW response path and the TLB refill port.
- Replaces the pure pass-through barrier with a DEPTH-entry registered FIFO, a valid/ready handshake, an sfence flush, and an occupancy count.
- Provides timing isolation between PTW and TLB; entries leave in arrival order.

Parameters:
- PPN_W, 20, width of the physical page number field
- DEPTH, 2, number of entry slots (≥1, any integer)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden)

Ports:
- clock  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  sfence.vma: discard all held entries this cycle
- in_valid  in  1  producer has an entry
- in_ready  out  1  slice accepts an entry
- in_ppn  in  PPN_W  incoming PPN
- in_flags  in  16  incoming flags, bit order per package (u,ae_ptw,ae_final,pf,gf,sw,sx,sr,pw,px,pr,ppp,pal,paa,eff,c; bit0=c … bit15=u)
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes the head entry
- out_ppn  out  PPN_W  head entry PPN
- out_flags  out  16  head entry flags
- count  out  CNT_W  current occupancy

Behaviour:
- Reset (async assert, sync release): count=0, read/write pointers=0, all storage=0.
  - Outputs at reset: out_valid=0, in_ready=1, out_ppn=0, out_flags=0, count=0.
- Push: in_valid & in_ready. Pop: out_valid & out_ready. Each transfers exactly one entry per cycle.
- in_ready = (count < DEPTH) & ~flush.
  - Depends only on registered state and flush; never combinationally on out_ready.
- out_valid = (count != 0) & ~flush.
- Latency: a pushed entry is visible on out_* the cycle after the push. No same-cycle bypass, including when empty.
- out_ppn/out_flags always show the slot at the read pointer. Values are don't-care when out_valid=0, but remain deterministic from the zero reset.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged; legal whenever 0<count<DEPTH
- Full (count=DEPTH): in_ready=0, so no push. A pop in that cycle frees a slot, which is visible as in_ready=1 the next cycle.
- Empty: out_valid=0, so a pop cannot occur.
- Pointers wrap from DEPTH−1 to 0; DEPTH need not be a power of two.
- Flush has priority over push and pop.
  - Next cycle: count=0 and pointers reset to 0.
  - Storage contents are not cleared.
  - Because in_ready and out_valid are forced low, no transfer occurs in the flush cycle.
- Reset asserted mid-operation: all in-flight entries are lost immediately and the block returns to reset values.
- No internal state machine beyond the pointers and counter; no overflow/underflow is possible by construction.

Optional Feature:
- Macro: TLB_ENTRY_SLICE_PERM_MASK_EN
- Defined:
  - On the output path, if any of pf, gf, ae_ptw or ae_final in the head entry is 1, then sw, sx, sr, pw, px, pr on out_flags are forced to 0. Fault bits and all other bits pass unchanged.
  - Masking is combinational on the output and does not change storage.
- Undefined: out_flags equals the stored flags bit-for-bit.

Decomposition:
- Shared package tlb_entry_pkg:
  - flag bit-index localparams (FLAG_C=0 … FLAG_U=15) and FLAGS_W=16
  - a packed tlb_entry_t struct {ppn, flags} with PPN width taken from a package constant PPN_W_DEFAULT=20
  - PERM_MASK constant (bits sw,sx,sr,pw,px,pr) and FAULT_MASK constant (bits pf,gf,ae_ptw,ae_final) for the optional feature
- One natural sub-module: tlb_entry_perm_mask.
  - Combinational fault-to-permission mask, instantiated only under the macro.
  - The FIFO core stays in the top module.

Test Plan:
- Reset, DEPTH=2: hold reset_n=0 → out_valid=0, in_ready=1, count=0, out_ppn=0. Release, then push ppn=0x12345 flags=0x0E40 → next cycle out_valid=1, out_ppn=0x12345, out_flags=0x0E40, count=1.
- Fill/full: out_ready=0, push 0xA, 0xB → count=2, in_ready=0. Third push is held. Set out_ready=1 → 0xA out, then 0xB, strict order. in_ready returns to 1 the cycle after the first pop.
- Simultaneous push and pop, DEPTH=3, count=1: push 0xC while popping → count stays 1, head becomes 0xC. Repeat 10 cycles to check pointer wrap and FIFO order.
- Flush: count=2, assert flush with in_valid=1 and out_ready=1 → in_ready=0 and out_valid=0 that cycle, count=0 next cycle. The pushed entry is not delivered later.
- Async reset mid-stream: deassert reset_n between clock edges with count=2 → count=0 and out_valid=0 immediately, without waiting for a clock edge.
- With TLB_ENTRY_SLICE_PERM_MASK_EN: push flags pf=1,sr=1,pr=1,u=1 → out_flags shows pf=1, u=1, sr=0, pr=0. Without the macro the same push → sr=1, pr=1.
